// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single synchronous core memory between instruction fetch (IF)
//   and the load/store unit (LS). One request is granted per cycle, the owner
//   of every in-flight read is remembered so the data returns to the right
//   requester, and LS may lock the port for atomic read-then-write sequences.
//
//   Optional feature macro: MEM_ARB_FAIRNESS_EN
//     Defined   : after MAX_LS_RUN consecutive LS grants taken while IF waits,
//                 IF wins the next contested cycle (never while locked).
//     Undefined : strict LS priority, no run counter.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           IF read request (held until granted)
//   if_gnt                   IF request accepted this cycle (combinational)
//   if_rvalid/if_rdata       IF read return, one cycle after the grant
//   ls_req/ls_we/ls_lock     LS request, write select, keep-ownership flag
//   ls_addr/ls_wdata         LS address and write data
//   ls_gnt                   LS request accepted this cycle (combinational)
//   ls_rvalid/ls_rdata       LS read return, one cycle after the grant
//   mem_re/mem_we            memory strobes, muxed from the winner
//   mem_addr/mem_wdata       memory address/data; hold when idle
//   mem_rdata                memory read data, valid the cycle after mem_re
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_LS_RUN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic                  ls_lock,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Elaboration-time guard on the fairness run length.
    if (MAX_LS_RUN < 1 || MAX_LS_RUN > 15) begin : g_bad_run
        $error("mem_port_arbiter: MAX_LS_RUN must be in 1..15");
    end

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Pending-read source encoding.
    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_LS = 1'b1;

    state_e                  state_q, state_d;
    logic                    pend_valid_q, pend_valid_d;
    logic                    pend_src_q, pend_src_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]   ls_rdata_q, ls_rdata_d;

    logic                    if_gnt_c;
    logic                    ls_gnt_c;
    logic                    fair_if_c;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int unsigned RUN_W = 4;

    logic [RUN_W-1:0]        run_q, run_d;

    // IF takes a contested cycle once LS has used up its run, unless locked.
    assign fair_if_c = (state_q == ST_OPEN) && (run_q == RUN_W'(MAX_LS_RUN));

    // Run counter: counts LS grants that made IF wait; saturates at the limit
    // so time spent locked cannot push it past the comparison value.
    always_comb begin
        run_d = run_q;
        if (!if_req || if_gnt_c) begin
            run_d = '0;
        end else if (ls_gnt_c && (run_q < RUN_W'(MAX_LS_RUN))) begin
            run_d = run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
`else
    assign fair_if_c = 1'b0;
`endif

    // Grant selection and lock FSM next-state.
    always_comb begin
        if_gnt_c = 1'b0;
        ls_gnt_c = 1'b0;
        state_d  = state_q;

        // No grants while reset is asserted.
        if (!rst) begin
            if (if_req && ls_req && fair_if_c) begin
                if_gnt_c = 1'b1;
            end else if (ls_req) begin
                ls_gnt_c = 1'b1;
            end else if (if_req && (state_q == ST_OPEN)) begin
                if_gnt_c = 1'b1;
            end
        end

        unique case (state_q)
            ST_OPEN: begin
                if (ls_gnt_c && ls_lock) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (ls_gnt_c && !ls_lock) begin
                    state_d = ST_OPEN;
                end
            end
            default: state_d = ST_OPEN;
        endcase
    end

    // Memory request mux; address/data hold their last value when idle.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (ls_gnt_c) begin
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
        end else if (if_gnt_c) begin
            mem_addr_d  = if_addr;
        end
    end

    // Pending read tracking: every granted read is returned next cycle.
    always_comb begin
        pend_valid_d = if_gnt_c || (ls_gnt_c && !ls_we);
        pend_src_d   = ls_gnt_c ? SRC_LS : SRC_IF;
    end

    // Return path: the owning requester sees mem_rdata directly, the other
    // keeps its previous data.
    always_comb begin
        if_rvalid  = pend_valid_q && (pend_src_q == SRC_IF);
        ls_rvalid  = pend_valid_q && (pend_src_q == SRC_LS);
        if_rdata_d = if_rvalid ? mem_rdata : if_rdata_q;
        ls_rdata_d = ls_rvalid ? mem_rdata : ls_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_OPEN;
            pend_valid_q <= 1'b0;
            pend_src_q   <= SRC_IF;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_src_q   <= pend_src_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    assign if_gnt    = if_gnt_c;
    assign ls_gnt    = ls_gnt_c;
    assign mem_re    = if_gnt_c || (ls_gnt_c && !ls_we);
    assign mem_we    = ls_gnt_c && ls_we;
    assign mem_addr  = mem_addr_d;
    assign mem_wdata = mem_wdata_d;
    assign if_rdata  = if_rdata_d;
    assign ls_rdata  = ls_rdata_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs change 1 time unit after each
//   rising edge; outputs are sampled 1 time unit later, inside the same cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic          ls_lock;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_LS_RUN (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_lock   (ls_lock),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req  = 1'b0; if_addr = '0;
        ls_req  = 1'b0; ls_we = 1'b0; ls_lock = 1'b0; ls_addr = '0; ls_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        mem_rdata = '0;
        if_req = 1'b1; ls_req = 1'b1;
        #3;
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt got %b exp 0", if_gnt); end
        checks++; if (ls_gnt !== 1'b0) begin errors++; $display("FAIL rst_ls_gnt got %b exp 0", ls_gnt); end
        checks++; if ({mem_re, mem_we, if_rvalid, ls_rvalid} !== 4'b0000) begin errors++; $display("FAIL rst_strobes got %b exp 0000", {mem_re, mem_we, if_rvalid, ls_rvalid}); end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL rst_mem_bus got %h/%h exp 0/0", mem_addr, mem_wdata); end
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_if_read();
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        checks++; if (if_gnt !== 1'b1 || mem_re !== 1'b1) begin errors++; $display("FAIL if_rd_gnt got gnt=%b re=%b exp 1/1", if_gnt, mem_re); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL if_rd_addr got %h exp 10", mem_addr); end
        tick();
        idle(); mem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL if_rd_data got v=%b d=%h exp 1/deadbeef", if_rvalid, if_rdata); end
        checks++; if (ls_rvalid !== 1'b0) begin errors++; $display("FAIL if_rd_lsv got %b exp 0", ls_rvalid); end
        tick();
        mem_rdata = 32'h0;
        #1;
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL if_rd_hold got v=%b d=%h exp 0/deadbeef", if_rvalid, if_rdata); end
        tick();
    endtask

    task automatic test_ls_priority();
        for (int c = 0; c < 4; c++) begin
            if_req = 1'b1; if_addr = 32'h14;
            ls_req = (c < 3); ls_addr = 32'h20;
            mem_rdata = 32'h100 + 32'(c);
            #1;
            if (c < 3) begin
                checks++; if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL prio_c%0d got ls=%b if=%b exp 1/0", c, ls_gnt, if_gnt); end
            end else begin
                checks++; if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin errors++; $display("FAIL prio_if_after got ls=%b if=%b exp 0/1", ls_gnt, if_gnt); end
            end
            if (c > 0) begin
                checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h100 + 32'(c)) begin errors++; $display("FAIL prio_rv_c%0d got v=%b d=%h exp 1/%h", c, ls_rvalid, ls_rdata, 32'h100 + 32'(c)); end
            end
            tick();
        end
        idle(); mem_rdata = 32'h55;
        #1;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h55 || ls_rvalid !== 1'b0) begin errors++; $display("FAIL prio_if_ret got v=%b d=%h lsv=%b exp 1/55/0", if_rvalid, if_rdata, ls_rvalid); end
        tick();
    endtask

    task automatic test_lock();
        if_req = 1'b1; if_addr = 32'h30;
        ls_req = 1'b1; ls_lock = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
        #1;
        checks++; if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL lock_rd got ls=%b if=%b exp 1/0", ls_gnt, if_gnt); end
        tick();
        ls_req = 1'b0; ls_lock = 1'b0; mem_rdata = 32'h12;
        #1;
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL lock_gap got if=%b exp 0", if_gnt); end
        checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h12) begin errors++; $display("FAIL lock_rdata got v=%b d=%h exp 1/12", ls_rvalid, ls_rdata); end
        tick();
        ls_req = 1'b1; ls_we = 1'b1; ls_lock = 1'b0; ls_addr = 32'h40; ls_wdata = 32'hAB;
        #1;
        checks++; if (if_gnt !== 1'b0 || ls_gnt !== 1'b1) begin errors++; $display("FAIL lock_wr_gnt got ls=%b if=%b exp 1/0", ls_gnt, if_gnt); end
        checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_wdata !== 32'hAB || mem_addr !== 32'h40) begin errors++; $display("FAIL lock_wr_bus got we=%b re=%b d=%h a=%h exp 1/0/ab/40", mem_we, mem_re, mem_wdata, mem_addr); end
        tick();
        ls_req = 1'b0; ls_we = 1'b0;
        #1;
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL lock_release got if=%b exp 1", if_gnt); end
        checks++; if (ls_rvalid !== 1'b0) begin errors++; $display("FAIL lock_wr_norv got %b exp 0", ls_rvalid); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_fairness();
        logic exp_if;
        if_req = 1'b1; if_addr = 32'h50;
        ls_req = 1'b1; ls_addr = 32'h60;
        for (int c = 0; c < 10; c++) begin
            #1;
`ifdef MEM_ARB_FAIRNESS_EN
            exp_if = ((c % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            checks++; if (if_gnt !== exp_if || ls_gnt !== !exp_if) begin errors++; $display("FAIL fair_c%0d got if=%b ls=%b exp %b/%b", c, if_gnt, ls_gnt, exp_if, !exp_if); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset_inflight();
        ls_req = 1'b1; ls_lock = 1'b1; ls_addr = 32'h80;
        #1;
        checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL rstf_gnt got %b exp 1", ls_gnt); end
        tick();
        rst = 1'b1; if_req = 1'b1; mem_rdata = 32'h77;
        #1;
        checks++; if ({ls_rvalid, if_rvalid, ls_gnt, if_gnt, mem_re, mem_we} !== 6'b0) begin errors++; $display("FAIL rstf_ctrl got %b exp 000000", {ls_rvalid, if_rvalid, ls_gnt, if_gnt, mem_re, mem_we}); end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || ls_rdata !== '0) begin errors++; $display("FAIL rstf_data got %h %h %h %h exp 0", mem_addr, mem_wdata, if_rdata, ls_rdata); end
        tick();
        rst = 1'b0; ls_req = 1'b0; ls_lock = 1'b0;
        #1;
        checks++; if (ls_rvalid !== 1'b0) begin errors++; $display("FAIL rstf_norv got %b exp 0", ls_rvalid); end
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rstf_open got if=%b exp 1", if_gnt); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_alternate();
        // cycle 0: IF @0
        if_req = 1'b1; if_addr = 32'h0;
        #1;
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL alt_g0 got %b exp 1", if_gnt); end
        tick();
        // cycle 1: LS @4, IF data 1
        idle(); ls_req = 1'b1; ls_addr = 32'h4; mem_rdata = 32'd1;
        #1;
        checks++; if (ls_gnt !== 1'b1 || if_rvalid !== 1'b1 || if_rdata !== 32'd1) begin errors++; $display("FAIL alt_c1 got g=%b v=%b d=%h exp 1/1/1", ls_gnt, if_rvalid, if_rdata); end
        tick();
        // cycle 2: IF @0, LS data 2
        idle(); if_req = 1'b1; if_addr = 32'h0; mem_rdata = 32'd2;
        #1;
        checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'd2 || if_rvalid !== 1'b0 || if_rdata !== 32'd1) begin errors++; $display("FAIL alt_c2 got lv=%b ld=%h iv=%b id=%h exp 1/2/0/1", ls_rvalid, ls_rdata, if_rvalid, if_rdata); end
        tick();
        // cycle 3: LS @4, IF data 3
        idle(); ls_req = 1'b1; ls_addr = 32'h4; mem_rdata = 32'd3;
        #1;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'd3 || ls_rdata !== 32'd2) begin errors++; $display("FAIL alt_c3 got iv=%b id=%h ld=%h exp 1/3/2", if_rvalid, if_rdata, ls_rdata); end
        tick();
        // cycle 4: idle, LS data 4; address holds last driven value
        idle(); mem_rdata = 32'd4;
        #1;
        checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'd4 || if_rdata !== 32'd3) begin errors++; $display("FAIL alt_c4 got lv=%b ld=%h id=%h exp 1/4/3", ls_rvalid, ls_rdata, if_rdata); end
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h4) begin errors++; $display("FAIL alt_idle got re=%b we=%b a=%h exp 0/0/4", mem_re, mem_we, mem_addr); end
        tick();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_ls_priority();
        test_lock();
        test_fairness();
        test_reset_inflight();
        test_alternate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous core memory between two requesters: instruction fetch (IF) and the load/store unit (LS, in front of memory_access).
- Grants one request per cycle and tracks the owner of each in-flight read, so read data is returned to the correct requester.
- Supports a lock so LS can perform an atomic read-then-write sequence, e.g. sub-word stores built as read-modify-write.
- Sits between the fetch/execute stages and the memory macro.

Parameters:
ADDR_WIDTH, 32, address width; equals `MEMORY_DEPTH in the core.
DATA_WIDTH, 32, data width; equals `MEMORY_WIDTH in the core.
MAX_LS_RUN, 4, consecutive LS grants allowed while IF is waiting (fairness feature only); legal range 1..15.

Ports:
clk  in  1  core clock; all state changes on rising edge.
rst  in  1  asynchronous, active-high reset.
if_req  in  1  IF read request; held until granted.
if_addr  in  ADDR_WIDTH  IF read address.
if_gnt  out  1  IF request accepted this cycle.
if_rvalid  out  1  if_rdata valid.
if_rdata  out  DATA_WIDTH  IF read data.
ls_req  in  1  LS request; held until granted.
ls_we  in  1  1 = write, 0 = read.
ls_lock  in  1  keep ownership after this grant.
ls_addr  in  ADDR_WIDTH  LS address.
ls_wdata  in  DATA_WIDTH  LS write data.
ls_gnt  out  1  LS request accepted this cycle.
ls_rvalid  out  1  ls_rdata valid.
ls_rdata  out  DATA_WIDTH  LS read data.
mem_re  out  1  memory read strobe.
mem_we  out  1  memory write strobe.
mem_addr  out  ADDR_WIDTH  memory address.
mem_wdata  out  DATA_WIDTH  memory write data.
mem_rdata  in  DATA_WIDTH  memory read data; valid the cycle after mem_re.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_re, mem_we = 0.
  - mem_addr, mem_wdata, if_rdata, ls_rdata = 0.
  - FSM in OPEN; pending register clear; run counter 0.
- Grant timing:
  - Grants are combinational from the requests and the registered state, in the same cycle.
  - At most one of if_gnt or ls_gnt is high in any cycle.
  - A grant means the request is presented to memory that cycle: mem_addr, mem_wdata, mem_we and mem_re are muxed from the winner.
- Idle outputs: with no grant, mem_re = mem_we = 0 and mem_addr/mem_wdata hold their last driven value.
- Pipelining:
  - Read latency is 1 cycle. Reads issue back-to-back with no bubble.
  - A pending register {valid, src} captures each granted read.
  - The next cycle, the matching if_rvalid or ls_rvalid is 1 and its rdata = mem_rdata. The other requester's rdata holds its value.
  - Writes (ls_we = 1) never produce rvalid.
- FSM states:
  - OPEN: LS beats IF when both request (fixed priority, baseline).
    - ls_gnt with ls_lock = 1 -> LOCKED.
  - LOCKED: if_gnt is forced to 0.
    - ls_gnt with ls_lock = 0 -> OPEN at the next edge.
    - ls_gnt with ls_lock = 1 -> stay in LOCKED.
    - ls_req = 0 -> stay in LOCKED; IF still blocked.
- Boundaries:
  - IF requesting while LS holds the lock: IF waits indefinitely.
  - Both requests drop mid-stream: an outstanding rvalid is still delivered.
  - rst asserted with a read in flight: the pending entry is discarded and no rvalid follows. State returns to OPEN immediately, not at the next edge.
  - Requests asserted during rst receive no grant.

Optional Feature:
Macro MEM_ARB_FAIRNESS_EN.
- Defined:
  - A 4-bit run counter increments on each ls_gnt taken in a cycle where if_req = 1.
  - It clears on if_gnt, or on any cycle where if_req = 0.
  - When the counter equals MAX_LS_RUN and the state is OPEN, IF wins the next contested cycle and the counter clears.
  - LOCKED always overrides fairness.
- Undefined: strict LS priority; the counter is absent from the RTL.

Test Plan:
1. Reset, then if_req = 1 with if_addr = 0x10 and mem_rdata = 0xDEADBEEF on the next cycle -> if_gnt = 1 in cycle 0; if_rvalid = 1 with if_rdata = 0xDEADBEEF in cycle 1; ls_rvalid stays 0.
2. if_req and ls_req (read, addr 0x20) both high for 3 cycles -> ls_gnt = 1 each cycle and if_gnt = 0; ls_rvalid = 1 in cycles 1..3; the IF grant comes in the cycle after ls_req drops.
3. LS read at 0x40 with ls_lock = 1, IF requesting, then LS write 0x000000AB at 0x40 with ls_lock = 0 two cycles later -> if_gnt = 0 through the write cycle; mem_we = 1 with mem_wdata = 0xAB; if_gnt = 1 the cycle after the write.
4. Fairness built with MAX_LS_RUN = 4, both requesters continuous -> grant pattern LS, LS, LS, LS, IF, repeating. Without the macro: LS only.
5. rst pulsed for 1 cycle in the cycle after a granted LS read -> no ls_rvalid; all outputs 0 during reset; FSM in OPEN afterwards.
6. Alternating single-cycle IF and LS reads, addresses 0x0/0x4, mem_rdata 1, 2, 3, 4 -> rvalids alternate IF, LS, IF, LS; each requester's rdata matches its own beat.
